// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_arbiter
//  Purpose  : Serves several GPU data-memory channels (read/write valid/ready)
//             from one single-port synchronous SRAM. Grants one request at a
//             time in round-robin order. Returns one-cycle ready pulses, and
//             registered read data for reads.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   clock, rising edge
//    reset          in   synchronous active-high reset
//    read_valid     in   [NUM_CHANNELS]            per-channel read request
//    read_address   in   [ADDR_BITS*NUM_CHANNELS]  per-channel read address
//    read_ready     out  [NUM_CHANNELS]            one-cycle read-done pulse
//    read_data      out  [DATA_BITS*NUM_CHANNELS]  per-channel read result
//    write_valid    in   [NUM_CHANNELS]            per-channel write request
//    write_address  in   [ADDR_BITS*NUM_CHANNELS]  per-channel write address
//    write_data     in   [DATA_BITS*NUM_CHANNELS]  per-channel write data
//    write_ready    out  [NUM_CHANNELS]            one-cycle write-done pulse
//    sram_en/we     out  SRAM access / write enable (high in ACCESS only)
//    sram_addr      out  [ADDR_BITS]  SRAM address (holds between accesses)
//    sram_wdata     out  [DATA_BITS]  SRAM write data (holds between writes)
//    sram_rdata     in   [DATA_BITS]  SRAM read data, valid cycle after read
//    busy           out  high whenever the FSM is not IDLE
// ============================================================================
module data_mem_arbiter #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CHANNELS-1:0]           read_valid,
  input  logic [ADDR_BITS*NUM_CHANNELS-1:0] read_address,
  output logic [NUM_CHANNELS-1:0]           read_ready,
  output logic [DATA_BITS*NUM_CHANNELS-1:0] read_data,
  input  logic [NUM_CHANNELS-1:0]           write_valid,
  input  logic [ADDR_BITS*NUM_CHANNELS-1:0] write_address,
  input  logic [DATA_BITS*NUM_CHANNELS-1:0] write_data,
  output logic [NUM_CHANNELS-1:0]           write_ready,
  output logic                              sram_en,
  output logic                              sram_we,
  output logic [ADDR_BITS-1:0]              sram_addr,
  output logic [DATA_BITS-1:0]              sram_wdata,
  input  logic [DATA_BITS-1:0]              sram_rdata,
  output logic                              busy
);

  localparam int              c_CH_W    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [c_CH_W-1:0] c_LAST_CH = c_CH_W'(NUM_CHANNELS - 1);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_ACCESS  = 2'd1;
  localparam logic [1:0] c_RESPOND = 2'd2;

  logic [1:0]              r_state;
  logic [1:0]              w_state_nxt;
  logic [c_CH_W-1:0]       r_rr_ptr;
  logic [c_CH_W-1:0]       r_winner;
  logic                    r_op_write;
  logic [NUM_CHANNELS-1:0] r_read_ready;
  logic [NUM_CHANNELS-1:0] r_write_ready;
  logic                    r_sram_en;
  logic                    r_sram_we;
  logic [ADDR_BITS-1:0]    r_sram_addr;
  logic [DATA_BITS-1:0]    r_sram_wdata;
  logic [DATA_BITS-1:0]    r_rdata [NUM_CHANNELS];

  logic [ADDR_BITS-1:0]    w_raddr [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]    w_waddr [NUM_CHANNELS];
  logic [DATA_BITS-1:0]    w_wdat  [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] w_elig;
  logic                    w_found;
  logic [c_CH_W-1:0]       w_win;
  int                      w_idx;
  logic                    w_grant;
  logic                    w_grant_write;
  logic                    w_capture;
  logic                    w_en_nxt;
  logic                    w_we_nxt;
  logic [ADDR_BITS-1:0]    w_addr_nxt;
  logic [DATA_BITS-1:0]    w_wdata_nxt;
  logic [NUM_CHANNELS-1:0] w_rready_nxt;
  logic [NUM_CHANNELS-1:0] w_wready_nxt;

  // Flat bus <-> per-channel views
  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
    assign w_raddr[g] = read_address [g*ADDR_BITS +: ADDR_BITS];
    assign w_waddr[g] = write_address[g*ADDR_BITS +: ADDR_BITS];
    assign w_wdat[g]  = write_data   [g*DATA_BITS +: DATA_BITS];
    assign read_data[g*DATA_BITS +: DATA_BITS] = r_rdata[g];
  end

  // A channel pulsing ready this cycle is about to drop valid, so it must
  // not be granted again on the same edge.
  assign w_elig = (read_valid | write_valid) & ~(r_read_ready | r_write_ready);

  // Round-robin search starting at r_rr_ptr, wrapping modulo NUM_CHANNELS
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NUM_CHANNELS) w_idx = w_idx - NUM_CHANNELS;
      if (!w_found && w_elig[c_CH_W'(w_idx)]) begin
        w_found = 1'b1;
        w_win   = c_CH_W'(w_idx);
      end
    end
  end

  // Read wins over write on the same channel; the write waits for a later grant
  assign w_grant_write = ~read_valid[w_win];

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= c_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:    if (w_found) w_state_nxt = c_ACCESS;
      c_ACCESS:  w_state_nxt = r_op_write ? c_IDLE : c_RESPOND;
      c_RESPOND: w_state_nxt = c_IDLE;
      default:   w_state_nxt = c_IDLE;
    endcase
  end

  // Output logic: next values of the registered SRAM and handshake outputs
  always_comb begin
    w_grant      = 1'b0;
    w_capture    = 1'b0;
    w_en_nxt     = 1'b0;
    w_we_nxt     = 1'b0;
    w_addr_nxt   = r_sram_addr;
    w_wdata_nxt  = r_sram_wdata;
    w_rready_nxt = '0;
    w_wready_nxt = '0;
    case (r_state)
      c_IDLE: begin
        if (w_found) begin
          w_grant    = 1'b1;
          w_en_nxt   = 1'b1;
          w_we_nxt   = w_grant_write;
          w_addr_nxt = w_grant_write ? w_waddr[w_win] : w_raddr[w_win];
          if (w_grant_write) w_wdata_nxt = w_wdat[w_win];
        end
      end
      c_ACCESS: begin
        if (r_op_write) w_wready_nxt[r_winner] = 1'b1;
      end
      c_RESPOND: begin
        w_capture               = 1'b1;
        w_rready_nxt[r_winner]  = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr      <= '0;
      r_winner      <= '0;
      r_op_write    <= 1'b0;
      r_read_ready  <= '0;
      r_write_ready <= '0;
      r_sram_en     <= 1'b0;
      r_sram_we     <= 1'b0;
      r_sram_addr   <= '0;
      r_sram_wdata  <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) r_rdata[i] <= '0;
    end else begin
      r_read_ready  <= w_rready_nxt;
      r_write_ready <= w_wready_nxt;
      r_sram_en     <= w_en_nxt;
      r_sram_we     <= w_we_nxt;
      r_sram_addr   <= w_addr_nxt;
      r_sram_wdata  <= w_wdata_nxt;
      if (w_grant) begin
        r_winner   <= w_win;
        r_op_write <= w_grant_write;
        r_rr_ptr   <= (w_win == c_LAST_CH) ? '0 : w_win + c_CH_W'(1);
      end
      if (w_capture) r_rdata[r_winner] <= sram_rdata;
    end
  end

  assign read_ready  = r_read_ready;
  assign write_ready = r_write_ready;
  assign sram_en     = r_sram_en;
  assign sram_we     = r_sram_we;
  assign sram_addr   = r_sram_addr;
  assign sram_wdata  = r_sram_wdata;
  assign busy        = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_arbiter
//  Purpose  : Randomized self-checking bench for data_mem_arbiter. Requesters
//             hold valid until ready, then drop it. A transaction-level model
//             (grant cycle, op, channel) predicts every output each cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_mem_arbiter;

  localparam int AB = 8;
  localparam int DB = 8;
  localparam int NC = 4;
  localparam int NCYC = 4500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [NC-1:0]     read_valid, write_valid, read_ready, write_ready;
  logic [AB*NC-1:0]  read_address, write_address;
  logic [DB*NC-1:0]  write_data, read_data;
  logic              sram_en, sram_we, busy;
  logic [AB-1:0]     sram_addr;
  logic [DB-1:0]     sram_wdata, sram_rdata;

  data_mem_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC)) u_dut (
    .clk(clk), .reset(reset),
    .read_valid(read_valid), .read_address(read_address),
    .read_ready(read_ready), .read_data(read_data),
    .write_valid(write_valid), .write_address(write_address),
    .write_data(write_data), .write_ready(write_ready),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .busy(busy)
  );

  // Single-port synchronous SRAM with a preload port used during reset
  logic [DB-1:0] mem [256];
  logic          pl_en;
  logic [AB-1:0] pl_a;
  logic [DB-1:0] pl_d;
  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    else if (sram_en) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         sram_rdata     <= mem[sram_addr];
    end
  end

  // Reference model: current transaction + architectural state
  logic [DB-1:0] ref_mem [256];
  int            cyc, m_ptr, t_g, t_ch, rate;
  bit            t_valid, t_wr;
  logic [AB-1:0] t_addr, m_addr;
  logic [DB-1:0] t_rd, m_wdata;
  logic [DB-1:0] m_rdata [NC];
  bit   [NC-1:0] prev_rr, prev_wr, e_rr, e_wr, elig;
  bit            e_en, e_we, e_busy, rst_now, found;
  int            win;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    read_valid = '0; write_valid = '0;
    read_address = '0; write_address = '0; write_data = '0;
    pl_en = 1'b1; pl_a = '0; pl_d = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    for (int i = 0; i < 16; i++) begin
      pl_a = AB'(i);
      pl_d = DB'($urandom_range(0, 255));
      ref_mem[i] = pl_d;
      @(posedge clk); #1;
    end
    pl_en = 1'b0;

    t_valid = 1'b0; t_wr = 1'b0; t_g = 0; t_ch = 0; t_addr = '0; t_rd = '0;
    m_ptr = 0; m_addr = '0; m_wdata = '0;
    for (int i = 0; i < NC; i++) m_rdata[i] = '0;
    prev_rr = '0; prev_wr = '0;
    cyc = 0;

    for (int n = 0; n < NCYC; n++) begin
      @(posedge clk); #1;
      cyc++;

      // Expected outputs for this cycle
      e_en   = t_valid && (cyc == t_g + 1);
      e_we   = e_en && t_wr;
      e_rr   = '0;
      e_wr   = '0;
      if (t_valid && !t_wr && cyc == t_g + 3) begin
        e_rr[t_ch]     = 1'b1;
        m_rdata[t_ch]  = t_rd;
      end
      if (t_valid && t_wr && cyc == t_g + 2) e_wr[t_ch] = 1'b1;
      e_busy = t_valid && (cyc > t_g) && (cyc < t_g + (t_wr ? 2 : 3));

      chk("read_ready",  32'(read_ready),  32'(e_rr));
      chk("write_ready", 32'(write_ready), 32'(e_wr));
      chk("sram_en",     32'(sram_en),     32'(e_en));
      chk("sram_we",     32'(sram_we),     32'(e_we));
      chk("sram_addr",   32'(sram_addr),   32'(m_addr));
      chk("busy",        32'(busy),        32'(e_busy));
      if (e_we) chk("sram_wdata", 32'(sram_wdata), 32'(m_wdata));
      for (int i = 0; i < NC; i++)
        chk($sformatf("read_data[%0d]", i), 32'(read_data[i*DB +: DB]), 32'(m_rdata[i]));

      // Requester behaviour for this cycle
      rate = (cyc < 1500) ? 60 : (cyc < 3000) ? 10 : 95;
      rst_now = (cyc < 3) || ($urandom_range(0, 299) == 0) ||
                (t_valid && !t_wr && cyc == t_g + 2 && $urandom_range(0, 9) == 0);
      reset = rst_now;
      for (int c = 0; c < NC; c++) begin
        if (prev_rr[c]) read_valid[c]  = 1'b0;
        if (prev_wr[c]) write_valid[c] = 1'b0;
      end
      if (rst_now) begin
        read_valid  = '0;
        write_valid = '0;
      end else begin
        for (int c = 0; c < NC; c++) begin
          if (!read_valid[c] && !prev_rr[c] && $urandom_range(0, 99) < rate) begin
            read_valid[c] = 1'b1;
            read_address[c*AB +: AB] = AB'($urandom_range(0, 15));
          end
          if (!write_valid[c] && !prev_wr[c] && $urandom_range(0, 99) < rate) begin
            write_valid[c] = 1'b1;
            write_address[c*AB +: AB] = AB'($urandom_range(0, 15));
            write_data[c*DB +: DB]    = DB'($urandom_range(0, 255));
          end
        end
      end
      prev_rr = e_rr;
      prev_wr = e_wr;

      // Model update at the end of this cycle
      if (rst_now) begin
        t_valid = 1'b0;
        m_ptr   = 0;
        m_addr  = '0;
        m_wdata = '0;
        for (int i = 0; i < NC; i++) m_rdata[i] = '0;
      end else if (!t_valid || cyc >= t_g + (t_wr ? 2 : 3)) begin
        elig  = (read_valid | write_valid) & ~(e_rr | e_wr);
        found = 1'b0;
        win   = 0;
        for (int k = 0; k < NC; k++) begin
          if (!found && elig[(m_ptr + k) % NC]) begin
            found = 1'b1;
            win   = (m_ptr + k) % NC;
          end
        end
        if (found) begin
          t_valid = 1'b1;
          t_g     = cyc;
          t_ch    = win;
          t_wr    = !read_valid[win];
          t_addr  = t_wr ? write_address[win*AB +: AB] : read_address[win*AB +: AB];
          m_addr  = t_addr;
          if (t_wr) begin
            m_wdata         = write_data[win*DB +: DB];
            ref_mem[t_addr] = m_wdata;
          end else begin
            t_rd = ref_mem[t_addr];
          end
          m_ptr = (win + 1) % NC;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Memory-side arbiter that serves the GPU's multi-channel data memory interface from one single-port synchronous SRAM. It accepts the per-channel read/write valid/ready requests the GPU's data memory controller issues, grants them one at a time in round-robin order, drives the SRAM, and returns one-cycle ready pulses with read data. It sits directly downstream of the GPU top level, between its data memory channels and the physical SRAM macro.

## Interface
Parameters:
- ADDR_BITS, 8, data memory address width
- DATA_BITS, 8, data word width
- NUM_CHANNELS, 4, number of request channels; must be ≥1

Ports:
- clk  in  1  clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- read_valid  in  NUM_CHANNELS  per-channel read request, held until matching read_ready
- read_address  in  ADDR_BITS × NUM_CHANNELS  read address per channel
- read_ready  out  NUM_CHANNELS  one-cycle pulse: read_data valid
- read_data  out  DATA_BITS × NUM_CHANNELS  registered read result, held until next read completes on that channel
- write_valid  in  NUM_CHANNELS  per-channel write request, held until matching write_ready
- write_address  in  ADDR_BITS × NUM_CHANNELS  write address per channel
- write_data  in  DATA_BITS × NUM_CHANNELS  write data per channel
- write_ready  out  NUM_CHANNELS  one-cycle pulse: write committed
- sram_en  out  1  SRAM access enable
- sram_we  out  1  SRAM write enable (valid when sram_en)
- sram_addr  out  ADDR_BITS  SRAM address
- sram_wdata  out  DATA_BITS  SRAM write data
- sram_rdata  in  DATA_BITS  SRAM read data, valid the cycle after a read access
- busy  out  1  high whenever state ≠ IDLE

## Operation
- FSM states: IDLE, ACCESS, RESPOND.
- IDLE: eligible channel = (read_valid | write_valid) and ready not asserted on that channel this cycle. If none, stay IDLE. Otherwise select winner by round-robin starting at rr_ptr, wrapping modulo NUM_CHANNELS; register sram_en=1, sram_we, sram_addr, sram_wdata; store winner index and op; rr_ptr ← winner+1 (wrap); → ACCESS.
- Within one channel, read has priority if read_valid and write_valid are both high; the write is served on a later grant.
- ACCESS: sram_en high this cycle only. Write: at end of cycle pulse write_ready[winner], → IDLE. Read: → RESPOND.
- RESPOND: capture sram_rdata into read_data[winner], pulse read_ready[winner], → IDLE.
- sram_en, sram_we deasserted in every state except ACCESS; sram_addr/sram_wdata hold last value.
- Ready-cooldown rule: a channel whose read_ready or write_ready is high in a cycle is ineligible in that cycle (the requester drops valid at that edge); prevents double service.
- read_data of non-winning channels never changes.

## Timing
- Reset values: read_ready=0, write_ready=0, all read_data=0, sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0, busy=0, rr_ptr=0, state IDLE.
- Write: request seen in IDLE at cycle N → sram_en/we high in N+1 → write_ready high in N+2 (one cycle).
- Read: request seen in IDLE at cycle N → sram_en high in N+1 → sram_rdata sampled end of N+2 → read_ready and read_data valid in N+3.
- Throughput: one write per 2 cycles, one read per 3 cycles; IDLE may grant the next channel in the same cycle a ready pulse is out.
- Fairness: with all channels continuously requesting, grants cycle 0,1,…,NUM_CHANNELS-1,0…; no channel waits more than NUM_CHANNELS grants.
- Reset mid-operation: next cycle returns to reset values; in-flight transaction abandoned, no ready issued. A write whose ACCESS cycle coincides with reset still commits in SRAM (sram_en already registered high).
- Valid dropped before ready (protocol violation) is undefined; transaction still completes and pulses ready.

## Test plan
- Reset then ch0 write addr 0x10 data 0xA5 at cycle N → sram_en=1, we=1, addr 0x10 in N+1; write_ready[0] high only in N+2; later ch0 read 0x10 → read_ready[0] in 3rd cycle after request, read_data[0]=0xA5.
- All 4 channels assert reads of addrs 0x00..0x03 (preloaded 0x11..0x44) in same cycle → read_ready order ch0,ch1,ch2,ch3, spaced 3 cycles apart, each read_data correct, one SRAM access at a time.
- Continuous requests on ch1 and ch3 after a grant to ch1 → next grant ch3, then ch1 (rr wrap); no channel served twice consecutively while other waits.
- Ch2 read_valid and write_valid together → read served first, write served on the following eligible grant; neither ready pulse longer than 1 cycle.
- Ch0 write with valid held exactly until ready edge → exactly one SRAM write, no re-grant in cooldown cycle.
- Reset asserted during RESPOND of a ch1 read → no read_ready[1], read_data[1]=0, state IDLE, busy=0 next cycle.
